sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Result-side companion to `sa_core`. It acknowledges per-row results from the core's `routport`/`rvalidport` via `outread` and captures them into a shadow bank. It then serialises the valid rows, lowest index first, onto a single 32-bit valid/ready stream for the writeback path. It sits between `sa_core` and the output buffer/DMA and is the only agent driving the core's `outread`.

## Interface
Parameters:
- `ROWS`, 8, number of systolic rows (= width of `rvalidport`, depth of `routport`)
- `DW`, 32, result width per row
- `RW`, `$clog2(ROWS)`, row-index width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `routport`  in  `DW` x `ROWS` (unpacked `[0:ROWS-1]`)  per-row results from core
- `rvalidport`  in  `[0:ROWS-1]`  per-row result-valid from core
- `outread`  out  1  acknowledge to core; results consumed this cycle
- `m_data`  out  `DW`  result beat
- `m_row`  out  `RW`  source row index of `m_data`
- `m_last`  out  1  final beat of the current captured vector
- `m_valid`  out  1  beat valid
- `m_ready`  in  1  downstream accept
- `busy`  out  1  any bank holds undrained rows
- `vec_count`  out  16  number of vectors fully drained since reset; wraps

## Operation
- Each bank holds `ROWS` x `DW` data plus a `ROWS`-bit pending mask.
- A bank is free when its pending mask is zero.
- Capture handshake:
  - `outread` is driven combinationally as `(rvalidport != 0) && free_bank_exists`.
  - On an edge where `outread == 1`, the free bank loads `routport` and sets its mask to `rvalidport`. Rows with `rvalidport` low are not stored.
  - The core must drop or advance `rvalidport` on the edge it samples `outread`. The drain never double-captures because the bank is no longer free.
- Drain FSM per active bank, states `IDLE`, `EMIT`:
  - `IDLE` -> `EMIT` when a bank has a nonzero mask.
  - In `EMIT`, `m_row` is the lowest set bit of the mask and `m_data` is that row's stored value.
  - On `m_valid && m_ready`, that mask bit clears.
  - `m_last` = 1 when exactly one mask bit remains.
  - On the `m_last` handshake: `vec_count` increments (mod 2^16), the bank becomes free, and the FSM moves to the next pending bank or to `IDLE`.
- Rows are never reordered. Zero-valid rows are skipped with no bubble.
- `m_data`, `m_row`, `m_last` are held stable while `m_valid && !m_ready`.
- `busy` = OR of all pending masks.

## Timing
- Reset values: `outread` 0, `m_valid` 0, `m_data` 0, `m_row` 0, `m_last` 0, `busy` 0, `vec_count` 0. All masks are cleared.
- `rst` asserted mid-drain discards all captured data immediately. `outread` is 0 in every cycle `rst` is high.
- Capture at edge t: `m_valid` = 1 from cycle t+1. The first beat can complete at edge t+1.
- Throughput is one beat per cycle while `m_ready` = 1. A vector with k valid rows drains in k cycles.
- Non-pingpong: the next `outread` can occur at the same edge as the `m_last` handshake, since the freed bank is free combinationally.
- `m_ready` held low stalls indefinitely.
- `rvalidport` stays unacknowledged (`outread` = 0) while no bank is free. This is backpressure to the core; no data is lost.

## Configuration
- `SA_DRAIN_PINGPONG_EN`:
  - Defined: two banks (A/B).
  - A capture may occur into the free bank while the other drains.
  - Banks drain in capture order, tracked by a 1-bit oldest pointer.
  - Back-to-back vectors stream with no idle cycle between the `m_last` beat and the next vector's first beat.
  - Undefined: a single bank. The next capture waits until `m_last` of the current vector handshakes.

## Test plan
- Reset check:
  - Hold `rst` = 1 for 3 cycles with `rvalidport` = 8'hFF.
  - Required: `outread` = 0 and all outputs at reset values throughout.
- Full vector:
  - `routport[i]` = i+100, `rvalidport` = 8'hFF, `m_ready` = 1.
  - Required: `outread` pulses 1 cycle; 8 beats, `m_row` 0..7, `m_data` 100..107; `m_last` on row 7 only; `vec_count` = 1.
- Sparse vector:
  - `rvalidport` = 8'b0010_0100 (rows 2 and 5 set; bit 0 is row 0), `routport[2]` = 32'hDEAD, `routport[5]` = 32'hBEEF.
  - Required: exactly 2 beats, (2, DEAD) then (5, BEEF) with `m_last`; no bubble between them.
- Backpressure:
  - Full vector with `m_ready` toggling 1,0,0,1,...
  - Required: `m_*` stable during stalls; all 8 beats in order.
  - A second `rvalidport` presented meanwhile sees `outread` = 0 until a bank is free.
- Mid-drain reset:
  - Assert `rst` after 3 of 8 beats.
  - Required: `m_valid` = 0 the next cycle; `busy` = 0; `vec_count` = 0; no residual beats after reset release.
- Pingpong (`SA_DRAIN_PINGPONG_EN` defined):
  - Two full vectors presented on consecutive cycles, `m_ready` = 1.
  - Required: both acknowledged within 2 cycles; 16 consecutive beats with no gap; `m_last` at beats 8 and 16; `vec_count` = 2.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain: captures per-row core results into a shadow bank and streams the valid rows, lowest index first, as one beat per row (`SA_DRAIN_PINGPONG_EN selects two banks)
module sa_result_drain #(
  parameter int ROWS = 8,
  parameter int DW = 32,
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] routport [0:ROWS-1],
  input  logic [0:ROWS-1] rvalidport,
  output logic          outread,
  output logic [DW-1:0] m_data,
  output logic [RW-1:0] m_row,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic [15:0]   vec_count
);
`ifdef SA_DRAIN_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] data_q [NB][ROWS];
  logic [ROWS-1:0] mask_q [NB];
  logic [ROWS-1:0] mask_d [NB];
  logic oldest_q, oldest_d;
  logic [15:0] vec_count_q, vec_count_d;
  logic [ROWS-1:0] rv, cur_mask;
  logic [NB-1:0] free;
  logic cap, hs, last_hs;
  int ones;
  assign vec_count = vec_count_q;
  // beat selection from the oldest bank, capture handshake and next-state
  always_comb begin
    rv = '0;
    for (int i = 0; i < ROWS; i++) rv[i] = rvalidport[i];
    m_valid = state_q == EMIT;
    cur_mask = mask_q[oldest_q];
    m_row = '0;
    ones = 0;
    for (int i = ROWS - 1; i >= 0; i--) if (cur_mask[i]) m_row = RW'(i);
    for (int i = 0; i < ROWS; i++) ones += int'(cur_mask[i]);
    m_data = m_valid ? data_q[oldest_q][m_row] : '0;
    m_last = m_valid && ones == 1;
    hs = m_valid && m_ready;
    last_hs = hs && m_last;
    busy = 1'b0;
    for (int b = 0; b < NB; b++) begin
      free[b] = mask_q[b] == '0 || (last_hs && oldest_q == 1'(b));
      busy = busy || mask_q[b] != '0;
    end
`ifdef SA_DRAIN_PINGPONG_EN
    cap = free[~oldest_q] ? ~oldest_q : oldest_q;
`else
    cap = 1'b0;
`endif
    outread = !rst && rv != '0 && free[cap];
    for (int b = 0; b < NB; b++) begin
      mask_d[b] = mask_q[b];
      if (hs && oldest_q == 1'(b)) mask_d[b][m_row] = 1'b0;
      if (outread && cap == 1'(b)) mask_d[b] = rv;
    end
`ifdef SA_DRAIN_PINGPONG_EN
    oldest_d = (mask_d[oldest_q] == '0 && mask_d[~oldest_q] != '0) ? ~oldest_q : oldest_q;
`else
    oldest_d = 1'b0;
`endif
    state_d = mask_d[oldest_d] != '0 ? EMIT : IDLE;
    vec_count_d = vec_count_q + 16'(last_hs);
  end
  // state, pending masks, drain order and vector count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      oldest_q <= 1'b0;
      vec_count_q <= '0;
      for (int b = 0; b < NB; b++) mask_q[b] <= '0;
    end else begin
      state_q <= state_d;
      oldest_q <= oldest_d;
      vec_count_q <= vec_count_d;
      for (int b = 0; b < NB; b++) mask_q[b] <= mask_d[b];
    end
  end
  // bank data: only rows flagged valid are written
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ROWS; i++)
        if (outread && cap == 1'(b) && rv[i]) data_q[b][i] <= routport[i];
  end
endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: scoreboard bench for sa_result_drain
module tb_sa_result_drain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rp [0:7];
  logic [0:7] rvalidport = 8'hFF;
  logic outread, m_last, m_valid, busy;
  logic m_ready = 1'b0;
  logic [31:0] m_data;
  logic [2:0] m_row;
  logic [15:0] vec_count;
  typedef struct packed { logic [2:0] row; logic [31:0] data; logic last; } beat_t;
  beat_t exp_q [$];
  int total = 0, bad = 0, beats = 0, exp_vec = 0;
`ifdef SA_DRAIN_PINGPONG_EN
  localparam int ACK_LAT = 1;
`else
  localparam int ACK_LAT = 8;
`endif

  sa_result_drain dut (
    .clk(clk), .rst(rst), .routport(rp), .rvalidport(rvalidport), .outread(outread),
    .m_data(m_data), .m_row(m_row), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    beat_t e;
    if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
      beats++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra: got row=%0d data=%h last=%b, expected no beat", m_row, m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        if ({m_row, m_data, m_last} !== e) begin
          bad++;
          $display("FAIL beat: got row=%0d data=%h last=%b, expected row=%0d data=%h last=%b",
                   m_row, m_data, m_last, e.row, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_vec;
    int n, k;
    n = 0;
    k = 0;
    for (int i = 0; i < 8; i++) if (rvalidport[i]) n++;
    for (int i = 0; i < 8; i++)
      if (rvalidport[i]) begin
        k++;
        exp_q.push_back({3'(i), rp[i], k == n});
      end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rvalidport = 8'hFF;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) rp[i] = $urandom;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({outread, m_valid, m_data, m_row, m_last, busy, vec_count} !== '0) begin
        bad++;
        $display("FAIL reset: got outread=%b m_valid=%b m_data=%h m_row=%0d m_last=%b busy=%b vec_count=%0d, expected all 0",
                 outread, m_valid, m_data, m_row, m_last, busy, vec_count);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rvalidport = 8'h00;
  endtask

  task automatic test_full;
    int c;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 100);
    rvalidport = 8'hFF;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outread !== 1'b1) begin bad++; $display("FAIL full_ack: got outread=%b, expected 1", outread); end
    push_vec();
    @(posedge clk); #1;
    rvalidport = 8'h00;
    @(negedge clk);
    total++;
    if (outread !== 1'b0) begin bad++; $display("FAIL full_ack_pulse: got outread=%b, expected 0", outread); end
    @(posedge clk); #1;
    c = 0;
    while (c < 50 && exp_q.size() != 0) begin @(negedge clk); @(posedge clk); #1; c++; end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain: got %0d beats left, expected 0", exp_q.size()); end
    exp_vec++;
    @(negedge clk);
    total++;
    if (vec_count !== 16'(exp_vec)) begin bad++; $display("FAIL full_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_sparse;
    int b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = $urandom;
    rp[2] = 32'hDEAD;
    rp[5] = 32'hBEEF;
    rvalidport = 8'b0010_0100;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outread !== 1'b1) begin bad++; $display("FAIL sparse_ack: got outread=%b, expected 1", outread); end
    push_vec();
    @(posedge clk); #1;
    rvalidport = 8'h00;
    b0 = beats;
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++;
    if (beats - b0 != 2) begin bad++; $display("FAIL sparse_no_bubble: got %0d beats in 2 cycles, expected 2", beats - b0); end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL sparse_end: got m_valid=%b, expected 0", m_valid); end
    exp_vec++;
    total++;
    if (vec_count !== 16'(exp_vec)) begin bad++; $display("FAIL sparse_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    logic [35:0] held;
    int rem, k;
    bit acked, stalled, exp_or;
    pat = 4'b1001;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 200);
    rvalidport = 8'hFF;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outread !== 1'b1) begin bad++; $display("FAIL bp_ack1: got outread=%b, expected 1", outread); end
    push_vec();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 300);
    k = 0;
    m_ready = pat[0];
    rem = 8;
    acked = 1'b0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 150 && (exp_q.size() != 0 || !acked); c++) begin
      @(negedge clk);
      if (stalled) begin
        total++;
        if ({m_row, m_data, m_last} !== held) begin
          bad++;
          $display("FAIL bp_stable: got %h, expected %h", {m_row, m_data, m_last}, held);
        end
      end
      if (!acked) begin
        exp_or = ACK_LAT == 1 || rem == 0 || (rem == 1 && m_ready);
        total++;
        if (outread !== exp_or) begin bad++; $display("FAIL bp_outread: got %b, expected %b (rem=%0d)", outread, exp_or, rem); end
        if (outread === 1'b1) begin acked = 1'b1; push_vec(); end
      end
      stalled = m_valid === 1'b1 && !m_ready;
      held = {m_row, m_data, m_last};
      if (m_ready && rem > 0) rem--;
      @(posedge clk); #1;
      if (acked) rvalidport = 8'h00;
      k++;
      m_ready = pat[k % 4];
    end
    total++;
    if (exp_q.size() != 0 || !acked) begin bad++; $display("FAIL bp_drain: got %0d beats left acked=%b, expected 0 and 1", exp_q.size(), acked); end
    rvalidport = 8'h00;
    m_ready = 1'b1;
    exp_vec += 2;
    @(negedge clk);
    total++;
    if (vec_count !== 16'(exp_vec)) begin bad++; $display("FAIL bp_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_back_to_back;
    int ack_at;
    bit gap;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 600);
    rvalidport = 8'hFF;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outread !== 1'b1) begin bad++; $display("FAIL b2b_ack1: got outread=%b, expected 1", outread); end
    push_vec();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 700);
    ack_at = 0;
    gap = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (ack_at == 0 && outread === 1'b1) begin ack_at = n; push_vec(); end
      if (n <= 16) gap |= m_valid !== 1'b1;
      else gap |= m_valid !== 1'b0;
      @(posedge clk); #1;
      if (ack_at != 0) rvalidport = 8'h00;
    end
    rvalidport = 8'h00;
    total++;
    if (ack_at != ACK_LAT) begin bad++; $display("FAIL b2b_ack2: got ack at cycle %0d, expected %0d", ack_at, ACK_LAT); end
    total++;
    if (gap) begin bad++; $display("FAIL b2b_gap: got gap in 16-beat stream, expected none"); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d beats left, expected 0", exp_q.size()); end
    exp_vec += 2;
    @(negedge clk);
    total++;
    if (vec_count !== 16'(exp_vec)) begin bad++; $display("FAIL b2b_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_random;
    int c;
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) rp[i] = $urandom;
      rvalidport = 8'($urandom_range(1, 255));
      m_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if (outread !== 1'b1) begin bad++; $display("FAIL rand_ack: got outread=%b, expected 1", outread); end
      push_vec();
      @(posedge clk); #1;
      rvalidport = 8'h00;
      m_ready = 1'($urandom);
      c = 0;
      while (c < 200 && exp_q.size() != 0) begin @(negedge clk); @(posedge clk); #1; m_ready = 1'($urandom); c++; end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d beats left, expected 0", exp_q.size()); end
      exp_vec++;
      @(negedge clk);
      total++;
      if (vec_count !== 16'(exp_vec)) begin bad++; $display("FAIL rand_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_mid_reset;
    int b0;
    bit resid;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rp[i] = 32'(i + 500);
    rvalidport = 8'hFF;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outread !== 1'b1) begin bad++; $display("FAIL midrst_ack: got outread=%b, expected 1", outread); end
    push_vec();
    b0 = beats;
    @(posedge clk); #1;
    rvalidport = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    total++;
    if (beats - b0 != 3) begin bad++; $display("FAIL midrst_beats: got %0d beats before reset, expected 3", beats - b0); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({m_valid, busy, vec_count, outread} !== '0) begin
      bad++;
      $display("FAIL midrst_state: got m_valid=%b busy=%b vec_count=%0d outread=%b, expected all 0", m_valid, busy, vec_count, outread);
    end
    exp_q.delete();
    exp_vec = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    resid = 1'b0;
    repeat (10) begin @(negedge clk); resid |= m_valid !== 1'b0 || busy !== 1'b0; end
    total++;
    if (resid) begin bad++; $display("FAIL midrst_residual: got activity after reset release, expected none"); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
